// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one byte-wide uart_tx interface.
// Define UART_TX_ARB_TIMEOUT_EN to add the mid-packet stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic                 tx_vld,
    output logic [7:0]           tx_data,
    input  logic                 tx_rdy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int LW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [LW-1:0]      gidx_q, gidx_d;
    logic [LW-1:0]      last_q, last_d;
    logic               tx_vld_q, tx_vld_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               accept;
    logic               timeout_hit;

    // First asserted requester after the pointer, wrapping modulo NUM_REQ.
    function automatic logic [LW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [LW-1:0]      ptr);
        logic [LW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && vld[idx]) begin
                pick  = LW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign req_rdy = grant_q & {NUM_REQ{~tx_vld_q | tx_rdy}};
    assign accept  = (state_q == OWN) && req_vld[gidx_q] && req_rdy[gidx_q];

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path infers a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        tx_vld_d  = tx_vld_q;
        tx_data_d = tx_data_q;

        if (tx_vld_q && tx_rdy) tx_vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_vld) begin
                    gidx_d          = rr_pick(req_vld, last_q);
                    grant_d         = '0;
                    grant_d[gidx_d] = 1'b1;
                    state_d         = OWN;
                end
            end
            OWN: begin
                if (accept) begin
                    tx_data_d = req_data[8*int'(gidx_q) +: 8];
                    tx_vld_d  = 1'b1;
                end
                if ((accept && req_last[gidx_q]) || timeout_hit) begin
                    grant_d = '0;
                    last_d  = gidx_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= LW'(NUM_REQ - 1);
            tx_vld_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            tx_vld_q  <= tx_vld_d;
            tx_data_q <= tx_data_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;

    assign timeout_hit   = (state_q == OWN) && !accept && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err_d = timeout_hit;

    // Counter sits at zero in IDLE, so entering OWN always starts from a clear count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || accept || timeout_hit) cnt_d = '0;
        else if (!req_vld[gidx_q])                    cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cycles;

    assign timeout_hit           = 1'b0;
    assign timeout_err           = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    assign grant   = grant_q;
    assign busy    = |grant_q;
    assign tx_vld  = tx_vld_q;
    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; per-requester byte queues
// drive the ports and a monitor records every byte the transmitter accepts.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_vld, req_last, req_rdy, grant;
    logic [N*8-1:0] req_data;
    logic           tx_vld, tx_rdy, busy, timeout_err;
    logic [7:0]     tx_data;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_rdy     (req_rdy),
        .tx_vld      (tx_vld),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         rdy_viol = 0;
    int         n;
    logic [8:0] pq [N][$];
    logic [7:0] txq[$];
    logic [7:0] exp_q[$];
    logic [N-1:0] rdy_seen;

    always @(posedge clk) if (rst_n && tx_vld && tx_rdy) txq.push_back(tx_data);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: present queue heads, sample req_rdy, pop what was accepted.
    task automatic step();
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                req_vld[i]        = 1'b1;
                req_data[8*i +: 8] = pq[i][0][7:0];
                req_last[i]       = pq[i][0][8];
            end else begin
                req_vld[i]        = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        #1;
        rdy_seen = req_rdy;
        acc      = req_vld & req_rdy;
        if ((req_rdy & ~grant) != '0 || !$onehot0(grant)) rdy_viol++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) void'(pq[i].pop_front());
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (pq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string tag);
        int k = 0;
        while (k < 200 && (pending() || busy || tx_vld)) begin
            step();
            k++;
        end
        check({tag, "_drain"}, 32'(k < 200), 32'd1);
    endtask

    task automatic check_txq(input string tag);
        check({tag, "_len"}, txq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i),
                  (i < txq.size()) ? {24'h0, txq[i]} : 32'hDEAD, {24'h0, exp_q[i]});
        txq.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_vld  = '0;
        req_data = '0;
        req_last = '0;
        tx_rdy   = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        txq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_tx_vld", tx_vld, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant", grant, 0);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Single 3-byte packet: latency and back-to-back throughput.
        pq[0].push_back(9'h0A1); pq[0].push_back(9'h0A2); pq[0].push_back(9'h1A3);
        step();
        check("t1_grant", grant, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_rdy_idle", rdy_seen, 0);
        step();
        check("t1_rdy", rdy_seen, 4'b0001);
        check("t1_vld", tx_vld, 1);
        check("t1_d0", tx_data, 8'hA1);
        step();
        check("t1_d1", tx_data, 8'hA2);
        step();
        check("t1_d2", tx_data, 8'hA3);
        check("t1_busy_low", busy, 0);
        check("t1_grant_low", grant, 0);
        drain("t1");
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        check_txq("t1");

        // Four simultaneous requesters from the reset pointer.
        do_reset();
        pq[0].push_back(9'h110); pq[1].push_back(9'h120);
        pq[2].push_back(9'h130); pq[3].push_back(9'h140);
        drain("t2");
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        check_txq("t2");

        // Requester 3 was last, so 0 wins; then 3 re-requesting loses to 2.
        pq[0].push_back(9'h111); pq[3].push_back(9'h141);
        drain("t2b");
        exp_q = '{8'h11, 8'h41};
        check_txq("t2b");
        pq[3].push_back(9'h143); pq[2].push_back(9'h132);
        drain("t2c");
        exp_q = '{8'h32, 8'h43};
        check_txq("t2c");

        // Requester 2 arrives while 1 is mid-packet: no interleaving.
        pq[1].push_back(9'h061); pq[1].push_back(9'h062);
        pq[1].push_back(9'h063); pq[1].push_back(9'h164);
        step();
        check("t3_grant", grant, 4'b0010);
        pq[2].push_back(9'h071); pq[2].push_back(9'h172);
        step();
        check("t3_no_rdy2", rdy_seen, 4'b0010);
        drain("t3");
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h72};
        check_txq("t3");

        // Transmitter stall holds the output stage.
        tx_rdy = 1'b0;
        pq[0].push_back(9'h055); pq[0].push_back(9'h156);
        step();
        check("t4_grant", grant, 4'b0001);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t4_hold_data%0d", i), tx_data, 8'h55);
            check($sformatf("t4_hold_rdy%0d", i), rdy_seen, 0);
        end
        check("t4_hold_vld", tx_vld, 1);
        tx_rdy = 1'b1;
        step();
        check("t4_rel_rdy", rdy_seen, 4'b0001);
        check("t4_next_data", tx_data, 8'h56);
        check("t4_next_vld", tx_vld, 1);
        drain("t4");
        exp_q = '{8'h55, 8'h56};
        check_txq("t4");

        // Requester 0 goes quiet mid-packet while requester 1 waits.
        do_reset();
        pq[0].push_back(9'h081); pq[1].push_back(9'h191);
        step();
        check("t5_grant0", grant, 4'b0001);
        step();
`ifdef UART_TX_ARB_TIMEOUT_EN
        n = 0;
        while (n < 40 && !timeout_err) begin
            step();
            n++;
        end
        check("t5_tmo_cycles", n, TMO);
        check("t5_tmo_grant", grant, 0);
        step();
        check("t5_tmo_pulse", timeout_err, 0);
        check("t5_grant1", grant, 4'b0010);
        drain("t5");
        exp_q = '{8'h81, 8'h91};
        check_txq("t5");
`else
        repeat (20) step();
        check("t5_held", grant, 4'b0001);
        check("t5_no_tmo", timeout_err, 0);
        pq[0].push_back(9'h182);
        drain("t5");
        exp_q = '{8'h81, 8'h82, 8'h91};
        check_txq("t5");
`endif

        // Asynchronous reset mid-packet drops the pending byte.
        pq[2].push_back(9'h0B1); pq[2].push_back(9'h0B2); pq[2].push_back(9'h1B3);
        step();
        step();
        check("t6_pre_vld", tx_vld, 1);
        #1 rst_n = 1'b0;
        for (int i = 0; i < N; i++) pq[i].delete();
        req_vld = '0;
        #1;
        check("t6_rst_vld", tx_vld, 0);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        txq.delete();
        pq[3].push_back(9'h1C1); pq[0].push_back(9'h1D1);
        step();
        check("t6_grant0", grant, 4'b0001);
        drain("t6");
        exp_q = '{8'hD1, 8'hC1};
        check_txq("t6");

        check("rdy_only_owner", rdy_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
